// File: rtl/rr_priority_encoder.sv
// Round-robin 8-to-3 priority encoder: sticky pending event bits are granted one
// at a time as an encoded line index on a valid/ready output port.
module rr_priority_encoder #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  output logic [W-1:0] out_code,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] pending,
  output logic         ovf
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  logic [0:0]   state;
  logic [W-1:0] ptr;

  logic         handshake;
  logic [N-1:0] clr;
  logic [N-1:0] drop;
  logic [N-1:0] pending_nxt;
  logic [N-1:0] rot;
  logic [W-1:0] base;
  logic [W-1:0] off;
  logic [W-1:0] sel;
  logic [W-1:0] idx;
  logic         found;

  assign out_valid = (state == HOLD);

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    handshake   = out_valid && out_ready;
    clr         = '0;
    if (handshake) clr[out_code] = 1'b1;
    drop        = req & pending & ~clr;
    pending_nxt = (pending & ~clr) | req;

    // A handshake moves the scan start past the granted line in the same cycle.
    base = handshake ? out_code + W'(1) : ptr;

    // Rotate the candidates so the scan start sits at bit 0, then take the lowest.
    rot = '0;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      idx    = base + W'(i);
      rot[i] = pending_nxt[idx];
    end

    off   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && rot[i]) begin
        off   = W'(i);
        found = 1'b1;
      end
    end
    sel = base + off;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      out_code <= '0;
      pending  <= '0;
      ovf      <= 1'b0;
    end else begin
      pending <= pending_nxt;
      ovf     <= |drop;
      case (state)
        IDLE: begin
          if (|pending_nxt) begin
            out_code <= sel;
            state    <= HOLD;
          end
        end
        HOLD: begin
          if (handshake) begin
            ptr <= out_code + W'(1);
            if (|pending_nxt) out_code <= sel;
            else              state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_priority_encoder.sv
// Self-checking bench for rr_priority_encoder: directed scenarios plus random
// traffic compared against a per-line behavioural model of pending/grant rules.
module tb_rr_priority_encoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req = 8'h00;
  logic       out_ready = 1'b0;
  logic [2:0] out_code;
  logic       out_valid;
  logic [7:0] pending;
  logic       ovf;

  int total = 0;
  int bad   = 0;

  // Reference model state
  bit m_pend[8];
  int m_code;
  int m_ptr;
  bit m_valid;
  bit m_ovf;

  rr_priority_encoder #(.N(8), .W(3)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .out_code(out_code),
    .out_valid(out_valid), .out_ready(out_ready), .pending(pending), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_pend[i] = 1'b0;
    m_code = 0; m_ptr = 0; m_valid = 1'b0; m_ovf = 1'b0;
  endtask

  function automatic logic [7:0] model_pend_vec();
    logic [7:0] v;
    for (int i = 0; i < 8; i++) v[i] = m_pend[i];
    return v;
  endfunction

  // One clock edge of the specified behaviour, line by line.
  task automatic model_edge(input logic [7:0] r, input bit rdy);
    bit hs, cleared, any_drop, found;
    bit newp[8];
    int j;
    hs = m_valid && rdy;
    any_drop = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cleared = hs && (i == m_code);
      if (r[i] && m_pend[i] && !cleared) any_drop = 1'b1;
      newp[i] = (m_pend[i] && !cleared) || r[i];
    end
    if (hs) m_ptr = (m_code + 1) % 8;
    if (!m_valid || hs) begin
      found = 1'b0;
      for (int k = 0; k < 8; k++) begin
        j = (m_ptr + k) % 8;
        if (!found && newp[j]) begin
          m_code = j;
          found  = 1'b1;
        end
      end
      m_valid = found;
    end
    for (int i = 0; i < 8; i++) m_pend[i] = newp[i];
    m_ovf = any_drop;
  endtask

  task automatic cmp(input string tag);
    check({tag, ".valid"}, 32'(out_valid), 32'(m_valid));
    check({tag, ".pending"}, 32'(pending), 32'(model_pend_vec()));
    check({tag, ".ovf"}, 32'(ovf), 32'(m_ovf));
    if (m_valid) check({tag, ".code"}, 32'(out_code), 32'(m_code));
  endtask

  task automatic step(input logic [7:0] r, input logic rdy, input string tag);
    @(negedge clk);
    req = r;
    out_ready = rdy;
    model_edge(r, rdy);
    @(posedge clk);
    #1;
    cmp(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req = 8'h00;
    out_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();

    // Reset values
    repeat (2) @(negedge clk);
    check("rst.valid", 32'(out_valid), 32'd0);
    check("rst.pending", 32'(pending), 32'h00);
    check("rst.ovf", 32'(ovf), 32'd0);
    check("rst.code", 32'(out_code), 32'd0);
    rst_n = 1'b1;

    // Single event on line 5
    step(8'h20, 1'b1, "s1a");
    check("s1.code5", 32'(out_code), 32'd5);
    step(8'h00, 1'b1, "s1b");
    check("s1.idle", 32'(out_valid), 32'd0);
    check("s1.empty", 32'(pending), 32'h00);

    // Two events at once: back-to-back codes 0 then 7
    do_reset();
    step(8'h81, 1'b1, "s2a");
    check("s2.code0", 32'(out_code), 32'd0);
    step(8'h00, 1'b1, "s2b");
    check("s2.code7", 32'(out_code), 32'd7);
    step(8'h00, 1'b1, "s2c");
    check("s2.idle", 32'(out_valid), 32'd0);

    // Back-pressure holds the code; re-pulsing a pending line overflows
    do_reset();
    step(8'h0C, 1'b0, "s3load");
    for (int i = 0; i < 10; i++) begin
      step(8'h00, 1'b0, "s3hold");
      check("s3.code2", 32'(out_code), 32'd2);
    end
    step(8'h04, 1'b0, "s3drop");
    check("s3.ovf", 32'(ovf), 32'd1);
    check("s3.pend", 32'(pending), 32'h0C);
    step(8'h00, 1'b0, "s3after");
    check("s3.ovf_pulse", 32'(ovf), 32'd0);

    // Full load rotates through every line without gaps
    do_reset();
    for (int i = 0; i < 9; i++) begin
      step(8'hFF, 1'b1, "s4rot");
      check("s4.seq", 32'(out_code), 32'(i % 8));
      check("s4.valid", 32'(out_valid), 32'd1);
    end

    // Set wins over clear on the granted line; it is re-granted last
    do_reset();
    step(8'h38, 1'b0, "s5load");
    check("s5.code3", 32'(out_code), 32'd3);
    step(8'h08, 1'b1, "s5hs");
    check("s5.code4", 32'(out_code), 32'd4);
    step(8'h00, 1'b1, "s5b");
    check("s5.code5", 32'(out_code), 32'd5);
    step(8'h00, 1'b1, "s5c");
    check("s5.code3b", 32'(out_code), 32'd3);
    step(8'h00, 1'b1, "s5d");

    // Asynchronous reset mid-cycle while holding a code
    do_reset();
    step(8'hF0, 1'b0, "s6load");
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("s6.valid", 32'(out_valid), 32'd0);
    check("s6.pending", 32'(pending), 32'h00);
    check("s6.ovf", 32'(ovf), 32'd0);
    check("s6.code", 32'(out_code), 32'd0);
    @(negedge clk);
    req = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step(8'h00, 1'b1, "s6post");

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 400; i++) begin
      step(8'($urandom & $urandom & $urandom), 1'($urandom_range(0, 1)), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rr_priority_encoder.md
Name: rr_priority_encoder

Overview:
- 8-to-3 encoder that is the inverse of the team's 3-to-8 one-hot decoder.
- Collects up to 8 event lines into sticky pending bits.
- Encodes one pending line per transfer into a 3-bit index, selected by round-robin priority.
- Presents the index on a valid/ready output port. It sits between interrupt/event sources and a downstream consumer that expects an encoded line number.

Parameters:
- N, 8, number of request lines; must be a power of two.
- W, 3, index width; must equal log2(N).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req  in  N  event pulses; each bit high in a cycle marks one event on that line.
- out_code  out  W  encoded index of the granted line.
- out_valid  out  1  out_code is valid.
- out_ready  in  1  consumer accepts out_code this cycle.
- pending  out  N  current sticky pending vector, for observability.
- ovf  out  1  one-cycle pulse: an event was dropped.

Behaviour:
- Reset (rst_n low, asynchronous):
  - pending = 0, out_code = 0, out_valid = 0, ovf = 0.
  - Round-robin pointer ptr = 0, state = IDLE.
  - Reset asserted mid-transfer discards the held code and all pending bits. No transfer completes on the edge where rst_n deasserts.
- Pending update at each edge:
  - pending_next = (pending & ~clr) | req.
  - clr is the one-hot of out_code when out_valid && out_ready, otherwise 0.
  - If req and clr hit the same bit in the same cycle, the set wins; the new event stays pending.
- Overflow:
  - A req bit that is already pending and is not being cleared that cycle is dropped.
  - ovf is registered and goes high for one cycle after the edge that dropped the event.
  - Several drops in one cycle produce a single ovf pulse.
- Selection:
  - Candidate vector cand = pending_next.
  - Pick the first set bit scanning ptr, ptr+1, …, N-1, 0, …, ptr-1, with wrap-around modulo N.
- State machine, two states:
  - IDLE (out_valid = 0):
    - At an edge, if cand != 0, register out_code = selected index, set out_valid = 1 and go to HOLD.
    - Latency: a req pulse in cycle t gives out_valid = 1 in cycle t+1.
  - HOLD (out_valid = 1), while out_ready = 0:
    - out_code and out_valid hold stable.
    - New req bits only update pending; they never change out_code.
  - HOLD, on handshake (out_valid && out_ready at an edge):
    - ptr = (out_code + 1) mod N.
    - If cand (already excluding the granted bit) is non-zero, load the next selection using the new ptr, stay in HOLD and keep out_valid = 1. Throughput is one code per cycle.
    - Otherwise set out_valid = 0 and go to IDLE.
- out_ready while IDLE is ignored.
- All index arithmetic is W bits wide and wraps modulo N. No other arithmetic.
- Fairness guarantee: with all N lines continuously re-pulsing, each line is granted exactly once every N transfers.

Test Plan:
- Reset with req=8'h00: out_valid=0, pending=8'h00, ovf=0. Then pulse req=8'h20 for one cycle with out_ready=1 → next cycle out_code=5, out_valid=1; one cycle later out_valid=0 and pending=0.
- Pulse req=8'h81 in one cycle with out_ready=1 → codes 0 then 7 on consecutive cycles, out_valid high for exactly 2 cycles.
- Hold out_ready=0 with pending=8'h0C, out_code=2 → code stays 2 for 10 cycles. Pulse req bit 2 again → ovf high for one cycle and pending unchanged.
- Rotation: keep req=8'hFF every cycle and out_ready=1 → code sequence 0,1,2,…,7,0 with no gaps and ovf pulsing.
- During a handshake on code 3, pulse req bit 3 in the same cycle → bit 3 remains pending and is re-granted after the other pending lines, per ptr=4.
- With out_valid=1 and pending=8'hF0, drop rst_n asynchronously mid-cycle → outputs clear immediately. After release with req=0, out_valid stays 0.
